// File: rtl/alu_uart_pkg.sv
// Shared types and constants for the UART-driven ALU command path.
package alu_uart_pkg;

  localparam int N_BITS_DEF = 8;
  localparam int NB_OP_DEF  = 6;

  localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'h20;
  localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'h22;
  localparam logic [NB_OP_DEF-1:0] OP_AND = 6'h24;
  localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'h25;
  localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'h26;
  localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'h27;
  localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'h03;
  localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'h02;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

endpackage

// File: rtl/timeout_counter.sv
// Inter-byte watchdog: counts while enabled, pulses o_expire on the last allowed cycle.
module timeout_counter #(
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expire
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit ACTIVE = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] LAST = ACTIVE ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] count_q, count_d;

  // Dropping the enable also clears, so every return to idle restarts from zero.
  always_comb begin
    count_d = count_q;
    if (i_clear || !i_enable || !ACTIVE)
      count_d = '0;
    else if (count_q != LAST)
      count_d = count_q + CW'(1);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) count_q <= '0;
    else         count_q <= count_d;
  end

  assign o_expire = ACTIVE && i_enable && (count_q == LAST);

endmodule

// File: rtl/alu_uart_sequencer.sv
// Collects A, B, opcode from the UART receiver, runs the ALU and hands the result to the transmitter.
//  state      | meaning
//  WAIT_A     | idle, waiting for operand A
//  WAIT_B     | waiting for operand B (timeout armed)
//  WAIT_OP    | waiting for opcode (timeout armed)
//  EXEC       | one cycle for the ALU to settle, result latched
//  SEND       | o_tx_start pulse
//  WAIT_TX    | waiting for the transmitter to finish
module alu_uart_sequencer
  import alu_uart_pkg::*;
#(
  parameter int N_BITS         = N_BITS_DEF,
  parameter int NB_OP          = NB_OP_DEF,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_rx_done_tick,
  input  logic [N_BITS-1:0] i_rx_data,
  input  logic              i_tx_done_tick,
  input  logic [N_BITS-1:0] i_alu_result,
  output logic [N_BITS-1:0] o_data_a,
  output logic [N_BITS-1:0] o_data_b,
  output logic [NB_OP-1:0]  o_op,
  output logic              o_tx_start,
  output logic [N_BITS-1:0] o_tx_data,
  output logic              o_busy,
  output logic              o_err_timeout,
  output logic              o_err_overrun
);

  state_t            state_q, state_d;
  logic [N_BITS-1:0] data_a_q, data_a_d;
  logic [N_BITS-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0]  op_q, op_d;
  logic [N_BITS-1:0] tx_data_q, tx_data_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_overrun_q, err_overrun_d;

  logic timer_en;
  logic timer_expire;
  logic unused_rx_hi;

  assign unused_rx_hi = ^i_rx_data[N_BITS-1:NB_OP];
  assign timer_en     = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_enable (timer_en),
    .i_clear  (i_rx_done_tick),
    .o_expire (timer_expire)
  );

  // An rx tick always beats a simultaneous expiry: the byte is taken first.
  always_comb begin
    state_d       = state_q;
    data_a_d      = data_a_q;
    data_b_d      = data_b_q;
    op_d          = op_q;
    tx_data_d     = tx_data_q;
    err_timeout_d = err_timeout_q;
    err_overrun_d = err_overrun_q;
    case (state_q)
      ST_WAIT_A: begin
        if (i_rx_done_tick) begin
          data_a_d = i_rx_data;
          state_d  = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (i_rx_done_tick) begin
          data_b_d = i_rx_data;
          state_d  = ST_WAIT_OP;
        end else if (timer_expire) begin
          err_timeout_d = 1'b1;
          state_d       = ST_WAIT_A;
        end
      end
      ST_WAIT_OP: begin
        if (i_rx_done_tick) begin
          op_d    = i_rx_data[NB_OP-1:0];
          state_d = ST_EXEC;
        end else if (timer_expire) begin
          err_timeout_d = 1'b1;
          state_d       = ST_WAIT_A;
        end
      end
      ST_EXEC: begin
        tx_data_d = i_alu_result;
        state_d   = ST_SEND;
        if (i_rx_done_tick) err_overrun_d = 1'b1;
      end
      ST_SEND: begin
        state_d = ST_WAIT_TX;
        if (i_rx_done_tick) err_overrun_d = 1'b1;
      end
      ST_WAIT_TX: begin
        if (i_tx_done_tick) state_d = ST_WAIT_A;
        if (i_rx_done_tick) err_overrun_d = 1'b1;
      end
      default: state_d = ST_WAIT_A;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q       <= ST_WAIT_A;
      data_a_q      <= '0;
      data_b_q      <= '0;
      op_q          <= '0;
      tx_data_q     <= '0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_a_q      <= data_a_d;
      data_b_q      <= data_b_d;
      op_q          <= op_d;
      tx_data_q     <= tx_data_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign o_data_a      = data_a_q;
  assign o_data_b      = data_b_q;
  assign o_op          = op_q;
  assign o_tx_data     = tx_data_q;
  assign o_err_timeout = err_timeout_q;
  assign o_err_overrun = err_overrun_q;
  assign o_tx_start    = (state_q == ST_SEND);
  assign o_busy        = (state_q != ST_WAIT_A);

endmodule
